// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer: pattern mode codes and the
// scan-direction encoding. Imported by the top level and the testbench.
package led_sequencer_pkg;

    // Pattern select codes carried on the mode input.
    localparam logic [1:0] MODE_BLINK = 2'd0;
    localparam logic [1:0] MODE_COUNT = 2'd1;
    localparam logic [1:0] MODE_SCAN  = 2'd2;
    localparam logic [1:0] MODE_FILL  = 2'd3;

    // Direction of the one-hot bounce in SCAN mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/step_sync.sv
// Synchroniser and rising-edge detector for a slow asynchronous square wave.
// The input is treated as data: it passes through SYNC_STAGES flops, then one
// history flop, and a rising edge is reported as a single-cycle level.
//
// Ports:
//   clk_in    sampling clock
//   rst       synchronous, active-high reset; clears every flop
//   async_in  asynchronous input wave
//   edge_out  high for one clk_in cycle after a synchronised rising edge
module step_sync #(
    parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s_last;

    assign s_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= s_last;
        end
    end

    assign edge_out = s_last & ~prev_q;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer driven by a divided square wave used as data.
// Each accepted rising edge of step_in advances one of four patterns
// (BLINK, COUNT, SCAN, FILL). A change of mode reloads the pattern's initial
// value and wins over a coincident step.
//
// Ports:
//   clk_in      board clock; all state updates on its rising edge
//   rst         synchronous, active-high reset
//   step_in     slow square wave, asynchronous to clk_in
//   mode        pattern select (BLINK, COUNT, SCAN, FILL)
//   hold        freezes the pattern; steps arriving while held are lost
//   leds        registered LED drive
//   step_pulse  one-cycle pulse per accepted step
//   wrap        one-cycle pulse when a step returns leds to the initial value
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,  // must be >= 2
    parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             step_in,
    input  logic [1:0]       mode,
    input  logic             hold,
    output logic [WIDTH-1:0] leds,
    output logic             step_pulse,
    output logic             wrap
);

    // Starting pattern for each mode; also the value that signals a wrap.
    function automatic logic [WIDTH-1:0] init_value(input logic [1:0] m);
        logic [WIDTH-1:0] v;
        v = '0;
        case (m)
            MODE_BLINK: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    v[i] = ~i[0];
                end
            end
            MODE_SCAN:  v[0] = 1'b1;
            MODE_COUNT: v = '0;
            MODE_FILL:  v = '0;
            default:    v = '0;
        endcase
        return v;
    endfunction

    logic             step_edge;
    logic [1:0]       mode_q;
    dir_e             dir_q,   dir_d;
    logic [WIDTH-1:0] leds_q,  leds_d;
    logic             pulse_q, pulse_d;
    logic             wrap_q,  wrap_d;

    logic             reload;
    logic             accept;
    logic [WIDTH-1:0] step_leds;
    dir_e             step_dir;

    step_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clk_in   (clk_in),
        .rst      (rst),
        .async_in (step_in),
        .edge_out (step_edge)
    );

    // Pattern advance for the currently registered mode.
    always_comb begin
        step_leds = leds_q;
        step_dir  = dir_q;
        case (mode_q)
            MODE_BLINK: step_leds = ~leds_q;
            MODE_COUNT: step_leds = leds_q + WIDTH'(1);
            MODE_SCAN: begin
                if (dir_q == DIR_UP) begin
                    if (leds_q[WIDTH-1]) begin
                        step_dir  = DIR_DOWN;
                        step_leds = {1'b0, leds_q[WIDTH-1:1]};
                    end else begin
                        step_leds = {leds_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (leds_q[0]) begin
                        step_dir  = DIR_UP;
                        step_leds = {leds_q[WIDTH-2:0], 1'b0};
                    end else begin
                        step_leds = {1'b0, leds_q[WIDTH-1:1]};
                    end
                end
            end
            MODE_FILL: step_leds = (&leds_q) ? '0 : {leds_q[WIDTH-2:0], 1'b1};
            default:   step_leds = leds_q;
        endcase
    end

    // A mode reload swallows any step landing on the same edge.
    always_comb begin
        reload  = (mode != mode_q);
        accept  = step_edge & ~hold & ~reload;
        leds_d  = leds_q;
        dir_d   = dir_q;
        pulse_d = accept;
        wrap_d  = accept && (step_leds == init_value(mode_q));
        if (reload) begin
            leds_d = init_value(mode);
            dir_d  = DIR_UP;
        end else if (accept) begin
            leds_d = step_leds;
            dir_d  = step_dir;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_q  <= MODE_BLINK;
            dir_q   <= DIR_UP;
            leds_q  <= init_value(MODE_BLINK);
            pulse_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode;
            dir_q   <= dir_d;
            leds_q  <= leds_d;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
        end
    end

    assign leds       = leds_q;
    assign step_pulse = pulse_q;
    assign wrap       = wrap_q;

endmodule
